// File: rtl/gate_ctrl.sv
// gate_ctrl: per-gate sequencer. Synchronizes and debounces the raw
// car sensor, sequences the gate through open / hold / close and reports
// each completed passage with a one-cycle pulse and a 16-bit wrap counter.
// Optional macro GATE_TIMEOUT_EN adds a stuck-open FAULT state.
module gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arrive,
  input  logic        inhibit,
  output logic        gate_open,
  output logic        passed,
  output logic [15:0] pass_count,
  output logic        busy,
  output logic        stuck
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_HOLD  = 2'd2
`ifdef GATE_TIMEOUT_EN
    , ST_FAULT = 2'd3
`endif
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic            arr_f_reg;
  logic [DW-1:0]   deb_cnt_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            hold_done;
  logic            pass_next;
  logic            passed_reg;
  logic [15:0]     pass_count_reg;

  // Two-flop synchronizer for the asynchronous sensor; sync_reg[1] is s2.
  always_ff @(posedge clk) begin
    if (reset) sync_reg <= 2'b00;
    else       sync_reg <= {sync_reg[0], arrive};
  end

  // Debouncer: the filtered level flips only after DEBOUNCE_CYCLES
  // consecutive edges on which s2 disagrees with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      arr_f_reg   <= 1'b0;
      deb_cnt_reg <= '0;
    end else if (sync_reg[1] != arr_f_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        arr_f_reg   <= ~arr_f_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end else begin
      deb_cnt_reg <= '0;
    end
  end

  // Hold timer: counts while in HOLD, sits at zero otherwise so every
  // HOLD entry starts a full interval.
  always_ff @(posedge clk) begin
    if (reset || state_reg != ST_HOLD) hold_cnt_reg <= '0;
    else if (!hold_done)               hold_cnt_reg <= hold_cnt_reg + 1'b1;
  end

  assign hold_done = (hold_cnt_reg == HOLD_LAST);

`ifdef GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_reg;
  logic          to_done;

  // Open-time watchdog: cleared outside OPEN, so it restarts on OPEN entry.
  always_ff @(posedge clk) begin
    if (reset || state_reg != ST_OPEN) to_cnt_reg <= '0;
    else if (!to_done)                 to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  assign to_done = (to_cnt_reg == TO_LAST);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; inhibit is only consulted while IDLE so a car is
  // never trapped by the gate closing on it.
  always_comb begin
    state_next = state_reg;
    pass_next  = 1'b0;
    case (state_reg)
      ST_IDLE: if (arr_f_reg && !inhibit) state_next = ST_OPEN;
      ST_OPEN: begin
        if (!arr_f_reg) state_next = ST_HOLD;
`ifdef GATE_TIMEOUT_EN
        else if (to_done) state_next = ST_FAULT;
`endif
      end
      ST_HOLD: begin
        if (arr_f_reg) begin
          state_next = ST_OPEN;
        end else if (hold_done) begin
          state_next = ST_IDLE;
          pass_next  = 1'b1;
        end
      end
`ifdef GATE_TIMEOUT_EN
      ST_FAULT: if (!arr_f_reg) state_next = ST_HOLD;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Pass reporting: registered pulse and wrapping passage counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      passed_reg     <= 1'b0;
      pass_count_reg <= 16'd0;
    end else begin
      passed_reg <= pass_next;
      if (pass_next) pass_count_reg <= pass_count_reg + 16'd1;
    end
  end

  assign gate_open  = (state_reg != ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign passed     = passed_reg;
  assign pass_count = pass_count_reg;
`ifdef GATE_TIMEOUT_EN
  assign stuck = (state_reg == ST_FAULT);
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl: table-driven, hand-sequenced and randomized checks of
// gate_ctrl. Two instances run on identical stimulus: default timing and
// the minimum timing (DEBOUNCE_CYCLES=1, HOLD_CYCLES=1). Each is followed
// every cycle by a behavioural model of the gate's passage rules.
module tb_gate_ctrl;

  localparam int TO_CYC = 20;
`ifdef GATE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PH_CLOSED = 0;
  localparam int PH_CAR    = 1;
  localparam int PH_WAIT   = 2;
  localparam int PH_STUCK  = 3;

  typedef struct packed {
    bit        s1;
    bit        s2;
    bit        filt;
    int        run;
    int        phase;
    int        left;
    int        open_t;
    bit        passed;
    bit [15:0] count;
  } model_t;

  typedef struct {
    int        n;
    bit        arr;
    bit        inh;
    bit        rst;
    bit        exp_open;
    bit        exp_busy;
    bit        exp_passed;
    bit [15:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arrive = 1'b0;
  logic inhibit = 1'b0;
  logic        open0, passed0, busy0, stuck0;
  logic [15:0] cnt0;
  logic        open1, passed1, busy1, stuck1;
  logic [15:0] cnt1;

  int n_pass = 0;
  int n_total = 0;
  model_t m0 = '0;
  model_t m1 = '0;

  always #5 clk = ~clk;

  gate_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(TO_CYC)) dut0 (
    .clk(clk), .reset(reset), .arrive(arrive), .inhibit(inhibit),
    .gate_open(open0), .passed(passed0), .pass_count(cnt0),
    .busy(busy0), .stuck(stuck0)
  );

  gate_ctrl #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(TO_CYC)) dut1 (
    .clk(clk), .reset(reset), .arrive(arrive), .inhibit(inhibit),
    .gate_open(open1), .passed(passed1), .pass_count(cnt1),
    .busy(busy1), .stuck(stuck1)
  );

  // Reference model: one call per rising edge, from the values seen before it.
  function automatic model_t mstep(model_t m, int d, int h, bit a, bit inh, bit rst);
    model_t n;
    n = m;
    n.passed = 1'b0;
    if (rst) begin
      n = '0;
      return n;
    end
    n.s1 = a;
    n.s2 = m.s1;
    if (m.s2 != m.filt) begin
      n.run = m.run + 1;
      if (n.run == d) begin
        n.filt = ~m.filt;
        n.run  = 0;
      end
    end else begin
      n.run = 0;
    end
    case (m.phase)
      PH_CLOSED: if (m.filt && !inh) begin
        n.phase  = PH_CAR;
        n.open_t = 0;
      end
      PH_CAR: begin
        if (!m.filt) begin
          n.phase = PH_WAIT;
          n.left  = h;
        end else begin
          n.open_t = m.open_t + 1;
          if (TO_EN && n.open_t == TO_CYC) n.phase = PH_STUCK;
        end
      end
      PH_WAIT: begin
        if (m.filt) begin
          n.phase  = PH_CAR;
          n.open_t = 0;
        end else begin
          n.left = m.left - 1;
          if (n.left == 0) begin
            n.phase  = PH_CLOSED;
            n.passed = 1'b1;
            n.count  = m.count + 16'd1;
          end
        end
      end
      default: if (!m.filt) begin
        n.phase = PH_WAIT;
        n.left  = h;
      end
    endcase
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // One clock: drive inputs, step both models at the edge, compare both DUTs.
  task automatic cycle(input bit a, input bit inh, input bit rst);
    arrive  = a;
    inhibit = inh;
    reset   = rst;
    @(posedge clk);
    m0 = mstep(m0, 4, 8, a, inh, rst);
    m1 = mstep(m1, 1, 1, a, inh, rst);
    @(negedge clk);
    check("m0_open",   {31'd0, open0},   {31'd0, m0.phase != PH_CLOSED});
    check("m0_busy",   {31'd0, busy0},   {31'd0, m0.phase != PH_CLOSED});
    check("m0_passed", {31'd0, passed0}, {31'd0, m0.passed});
    check("m0_count",  {16'd0, cnt0},    {16'd0, m0.count});
    check("m0_stuck",  {31'd0, stuck0},  {31'd0, m0.phase == PH_STUCK});
    check("m1_open",   {31'd0, open1},   {31'd0, m1.phase != PH_CLOSED});
    check("m1_busy",   {31'd0, busy1},   {31'd0, m1.phase != PH_CLOSED});
    check("m1_passed", {31'd0, passed1}, {31'd0, m1.passed});
    check("m1_count",  {16'd0, cnt1},    {16'd0, m1.count});
    check("m1_stuck",  {31'd0, stuck1},  {31'd0, m1.phase == PH_STUCK});
  endtask

  task automatic seg(input int n, input bit a, input bit inh, input bit rst);
    for (int i = 0; i < n; i++) cycle(a, inh, rst);
  endtask

  // Hand-computed expectations for the default-timing instance.
  task automatic expect0(input string name, input bit op, input bit ps,
                         input bit [15:0] cnt, input bit stk);
    check({name, "_open"},   {31'd0, open0},   {31'd0, op});
    check({name, "_busy"},   {31'd0, busy0},   {31'd0, op});
    check({name, "_passed"}, {31'd0, passed0}, {31'd0, ps});
    check({name, "_count"},  {16'd0, cnt0},    {16'd0, cnt});
    check({name, "_stuck"},  {31'd0, stuck0},  {31'd0, stk});
  endtask

  vec_t vecs[15];

  initial begin
    // Normal passage, glitch rejection, inhibit (default timing).
    vecs[0]  = '{2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[6]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[10] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[11] = '{5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[12] = '{14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[13] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[14] = '{5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

    for (int v = 0; v < 15; v++) begin
      seg(vecs[v].n, vecs[v].arr, vecs[v].inh, vecs[v].rst);
      expect0($sformatf("vec%0d", v), vecs[v].exp_open, vecs[v].exp_passed,
              vecs[v].exp_cnt, 1'b0);
      check($sformatf("vec%0d_busy", v), {31'd0, busy0}, {31'd0, vecs[v].exp_busy});
    end

    // Re-arrival during HOLD: the gate must go back to OPEN, so the pass
    // lands only after the second departure.
    seg(7, 1'b1, 1'b0, 1'b0);   expect0("rearr_open", 1'b1, 1'b0, 16'd2, 1'b0);
    seg(5, 1'b0, 1'b0, 1'b0);   expect0("rearr_fall", 1'b1, 1'b0, 16'd2, 1'b0);
    seg(10, 1'b1, 1'b0, 1'b0);  expect0("rearr_back", 1'b1, 1'b0, 16'd2, 1'b0);
    seg(14, 1'b0, 1'b0, 1'b0);  expect0("rearr_hold", 1'b1, 1'b0, 16'd2, 1'b0);
    seg(1, 1'b0, 1'b0, 1'b0);   expect0("rearr_pass", 1'b0, 1'b1, 16'd3, 1'b0);

    // Reset in HOLD clears everything and the interrupted passage is lost.
    seg(7, 1'b1, 1'b0, 1'b0);
    seg(9, 1'b0, 1'b0, 1'b0);   expect0("rst_inhold", 1'b1, 1'b0, 16'd3, 1'b0);
    seg(1, 1'b0, 1'b0, 1'b1);   expect0("rst_clear",  1'b0, 1'b0, 16'd0, 1'b0);
    seg(20, 1'b0, 1'b0, 1'b0);  expect0("rst_after",  1'b0, 1'b0, 16'd0, 1'b0);

    // Sensor held across reset release: reopens 7 cycles later.
    seg(1, 1'b1, 1'b0, 1'b1);
    seg(6, 1'b1, 1'b0, 1'b0);   expect0("held_closed", 1'b0, 1'b0, 16'd0, 1'b0);
    seg(1, 1'b1, 1'b0, 1'b0);   expect0("held_open",   1'b1, 1'b0, 16'd0, 1'b0);

    // Long occupancy: stuck after TO_CYC cycles in OPEN only with the timeout.
    seg(1, 1'b0, 1'b0, 1'b1);
    seg(7, 1'b1, 1'b0, 1'b0);   expect0("to_open",    1'b1, 1'b0, 16'd0, 1'b0);
    seg(19, 1'b1, 1'b0, 1'b0);  expect0("to_before",  1'b1, 1'b0, 16'd0, 1'b0);
    seg(1, 1'b1, 1'b0, 1'b0);   expect0("to_hit",     1'b1, 1'b0, 16'd0, TO_EN);
    seg(13, 1'b1, 1'b0, 1'b0);  expect0("to_hold",    1'b1, 1'b0, 16'd0, TO_EN);
    seg(6, 1'b0, 1'b0, 1'b0);   expect0("to_leave",   1'b1, 1'b0, 16'd0, TO_EN);
    seg(1, 1'b0, 1'b0, 1'b0);   expect0("to_clear",   1'b1, 1'b0, 16'd0, 1'b0);
    seg(7, 1'b0, 1'b0, 1'b0);   expect0("to_wait",    1'b1, 1'b0, 16'd0, 1'b0);
    seg(1, 1'b0, 1'b0, 1'b0);   expect0("to_pass",    1'b0, 1'b1, 16'd1, 1'b0);

    // Randomized runs of sensor level, inhibit and occasional reset.
    for (int s = 0; s < 160; s++) begin
      int len;
      bit a, inh, rst;
      len = $urandom_range(1, 25);
      a   = 1'($urandom_range(0, 1));
      inh = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 40) == 0);
      cycle(a, inh, rst);
      seg(len - 1, a, inh, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gate_ctrl.md
# gate_ctrl

Per-gate sequencer for the parking-lot design, one instance per gate (entrance and exit), sitting between the raw virtual-GPIO gate sensor and the top-level lot logic. It synchronizes and debounces the "car waiting" sensor, drives the gate-open control through an open/hold/close sequence, and reports each completed passage. Its `passed` pulse and `pass_count` feed the top level's car totals and hourly tracking in place of edge-detecting the open signal.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive cycles the synchronized sensor must differ from the filtered level before the level flips; must be ≥1.
- `HOLD_CYCLES`, 8: cycles the gate stays open after the car clears the sensor; must be ≥1.
- `TIMEOUT_CYCLES`, 1000: cycles in OPEN before a stuck fault; only used when `GATE_TIMEOUT_EN` is defined.

- `clk` in 1: system clock. One clock domain; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `arrive` in 1: raw sensor, 1 = car present at gate; asynchronous to `clk`.
- `inhibit` in 1: 1 = do not open (entrance: lot full; exit: tie 0).
- `gate_open` out 1: gate control, 1 = open.
- `passed` out 1: one-cycle pulse per completed passage.
- `pass_count` out 16: total completed passages since reset.
- `busy` out 1: 1 whenever the FSM is not in IDLE.
- `stuck` out 1: timeout fault flag. Constant 0 when `GATE_TIMEOUT_EN` is undefined.

## Operation
- **Input path.** `arrive` → 2-flop synchronizer (`s2`) → debouncer producing filtered level `arr_f`.
  - Debounce counter clears whenever `s2 == arr_f`.
  - It increments whenever `s2 != arr_f`.
  - `arr_f` toggles on the `DEBOUNCE_CYCLES`-th consecutive differing edge, and the counter clears.
- **FSM states:** IDLE, OPEN, HOLD, and FAULT (FAULT exists only with the macro).
  - IDLE: go to OPEN when `arr_f`=1 and `inhibit`=0.
  - OPEN: go to HOLD when `arr_f`=0.
  - HOLD: a counter runs for exactly `HOLD_CYCLES` cycles.
    - `arr_f`=1 during HOLD → return to OPEN; no pass is counted and the hold counter reloads on the next HOLD entry.
    - Expiry → IDLE.
- **Outputs.**
  - `gate_open` = state ∈ {OPEN, HOLD, FAULT}, decoded from the state register.
  - `busy` = state ≠ IDLE.
- **Pass reporting.** On the HOLD→IDLE edge, `passed` is registered to 1 for one cycle and `pass_count` increments. `pass_count` wraps 16'hFFFF→0.
- **Inhibit.** Sampled only in IDLE. Asserting `inhibit` in OPEN/HOLD never closes the gate on a car.
- **Reset values.** Reset clears the synchronizer, `arr_f`, all counters and `pass_count` to 0, and forces IDLE. All outputs read 0 the cycle after a reset edge, including a reset mid-passage; no pass is counted for an interrupted passage.

## Timing
- Raw `arrive` rising before edge 1 and held stable:
  - `arr_f`=1 after edge `DEBOUNCE_CYCLES`+2.
  - `gate_open`=1 after edge `DEBOUNCE_CYCLES`+3. Default: 7 cycles.
- Raw `arrive` falling before edge 1 while OPEN:
  - HOLD entered after edge `DEBOUNCE_CYCLES`+3.
  - IDLE entered, with `gate_open`=0, `passed`=1 and `pass_count` incremented, after edge `DEBOUNCE_CYCLES`+3+`HOLD_CYCLES`. Default: 15.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) have no effect.
- If `arrive` is held across reset release, the gate reopens `DEBOUNCE_CYCLES`+3 cycles after the first non-reset edge.
- `inhibit` must be 0 on the same edge `arr_f` is seen as 1 for the IDLE→OPEN transition; there is no extra latency.

## Configuration
- Macro: `GATE_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in OPEN and clears on OPEN entry.
  - Reaching `TIMEOUT_CYCLES` → FAULT. In FAULT, `gate_open`=1 and `stuck`=1.
  - FAULT→HOLD when `arr_f`=0; `stuck` clears on that edge.
  - Passage then completes normally and is counted.
- **Undefined:**
  - No FAULT state and no timeout counter.
  - `stuck` is constant 0.
  - OPEN persists indefinitely while `arr_f`=1.

## Test plan
1. **Normal passage.** Defaults; reset, then `arrive`=1 for 20 cycles, then 0 → `gate_open` rises 7 cycles after `arrive` rises and falls 15 cycles after `arrive` falls; `passed` high exactly 1 cycle; `pass_count`=1.
2. **Glitch rejection.** 3-cycle `arrive` pulse → `gate_open`, `busy` and `passed` stay 0; `pass_count` stays 0.
3. **Inhibit.** `inhibit`=1, `arrive`=1 for 30 cycles → gate stays closed. Drop `inhibit` with `arrive` still 1 → `gate_open`=1 one cycle later. Raising `inhibit` in OPEN keeps the gate open.
4. **Re-arrival in HOLD.** `arrive` falls, then re-rises 2 cycles after HOLD entry and stays high 10 cycles before falling → state returns to OPEN with no `passed`; exactly one pass counted at the end.
5. **Reset mid-passage and wrap.** Reset asserted in HOLD → all outputs 0 next cycle, `pass_count`=0. Separately, force 65536 passages (`HOLD_CYCLES`=1, `DEBOUNCE_CYCLES`=1) → `pass_count` wraps to 0.
6. **Timeout (`GATE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20).** Hold `arrive` high 40 cycles → `stuck`=1 after 20 cycles in OPEN, with the gate still open. Release → `stuck`=0 on HOLD entry; `passed` fires and `pass_count`=1.
